// File: rtl/wb_cmd_master.sv
// Wishbone classic initiator: queued commands become single-beat bus cycles,
// each answered by exactly one in-order response (read data, write ack or timeout).
module wb_cmd_master #(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 255,
    parameter int TO_W      = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        rsp_we,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i,
    output logic        busy
);
    localparam int AW = $clog2(CMD_DEPTH);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } cmd_t;

    cmd_t          mem_q [CMD_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    state_t        state_q, state_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [31:0]   rsp_dat_q, rsp_dat_d;
    logic          rsp_err_q, rsp_err_d;
    logic          rsp_we_q, rsp_we_d;

    logic fifo_empty, fifo_full, push, pop, to_hit;
    cmd_t head;

    // Extra MSB on the pointers separates full from empty when the indices match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign cmd_ready  = !fifo_full && !wb_rst_i;
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state_q == IDLE) && !fifo_empty;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign to_hit     = (cnt_q == TO_W'(TIMEOUT - 1));
    assign wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push};
    assign rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};

    always_ff @(posedge wb_clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{we: cmd_we, adr: cmd_adr, dat: cmd_dat, sel: cmd_sel};
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cyc_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            sel_q     <= '0;
            cnt_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
            rsp_we_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cyc_q     <= cyc_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
            rsp_we_q  <= rsp_we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!fifo_empty) state_d = BUS;
            BUS:     if (wbm_ack_i || to_hit) state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; an ack on the timeout cycle takes priority over the abort.
    always_comb begin
        cyc_d     = cyc_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        rsp_we_d  = rsp_we_q;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    we_d  = head.we;
                    adr_d = head.adr;
                    dat_d = head.dat;
                    sel_d = head.sel;
                    cyc_d = 1'b1;
                    cnt_d = '0;
                end
            end
            BUS: begin
                if (wbm_ack_i) begin
                    cyc_d     = 1'b0;
                    rsp_dat_d = we_q ? 32'h0 : wbm_dat_i;
                    rsp_err_d = 1'b0;
                    rsp_we_d  = we_q;
                end else if (to_hit) begin
                    cyc_d     = 1'b0;
                    rsp_dat_d = 32'h0;
                    rsp_err_d = 1'b1;
                    rsp_we_d  = we_q;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rsp_valid = (state_q == RESP);
        busy      = !fifo_empty || (state_q != IDLE);
        rsp_dat   = rsp_dat_q;
        rsp_err   = rsp_err_q;
        rsp_we    = rsp_we_q;
        wbm_cyc_o = cyc_q;
        wbm_stb_o = cyc_q;
        wbm_we_o  = we_q;
        wbm_adr_o = adr_q;
        wbm_dat_o = dat_q;
        wbm_sel_o = sel_q;
    end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Directed bench for wb_cmd_master: a behavioural slave with programmable wait
// states plus a response scoreboard fed at command-push time.
module tb_wb_cmd_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        rsp_we;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i = 1'b0;
    logic [31:0] wbm_dat_i = '0;
    logic        busy;

    logic [15:0] slv_wait = 16'd0;
    logic        slv_fixed_en = 1'b0;
    logic [31:0] slv_fixed = '0;
    logic [15:0] stb_cnt = '0;
    int          run_len = 0;
    int          last_len = 0;
    logic        adr_glitch = 1'b0;
    logic        prev_stb = 1'b0;
    logic [31:0] prev_adr = '0;

    logic [33:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    wb_cmd_master dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .rsp_we(rsp_we),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] slv_data(input logic [31:0] adr);
        return adr ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [33:0] mk_exp(input logic we, input logic err, input logic [31:0] rd);
        return {we, err, (we || err) ? 32'h0 : rd};
    endfunction

    // Slave: acks on the (slv_wait+1)th strobe cycle; 16'hFFFF never acks.
    always @(negedge clk) begin
        if (wbm_stb_o && stb_cnt == slv_wait) begin
            wbm_ack_i = 1'b1;
            wbm_dat_i = slv_fixed_en ? slv_fixed : slv_data(wbm_adr_o);
        end else begin
            wbm_ack_i = 1'b0;
            wbm_dat_i = 32'hDEAD_BEEF;
        end
    end

    always @(posedge clk) begin
        stb_cnt  <= (wbm_stb_o && !wbm_ack_i) ? stb_cnt + 16'd1 : 16'd0;
        prev_stb <= wbm_stb_o;
        prev_adr <= wbm_adr_o;
        if (wbm_stb_o && prev_stb && wbm_adr_o != prev_adr) adr_glitch <= 1'b1;
        if (wbm_stb_o) run_len <= run_len + 1;
        else if (run_len != 0) begin
            last_len <= run_len;
            run_len  <= 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [33:0] exp);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        while (!cmd_ready && n < 1000) begin
            tick();
            n++;
        end
        check("push_ready", {63'h0, cmd_ready}, 64'h1);
        tick();
        cmd_valid = 1'b0;
        exp_q.push_back(exp);
    endtask

    task automatic expect_rsp(input string tag);
        int n = 0;
        logic [33:0] exp;
        rsp_ready = 1'b1;
        while (!rsp_valid && n < 1000) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {63'h0, rsp_valid}, 64'h1);
        if (rsp_valid && exp_q.size() != 0) begin
            exp = exp_q.pop_front();
            check(tag, {30'h0, rsp_we, rsp_err, rsp_dat}, {30'h0, exp});
        end
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        int seen;
        logic [31:0] a;

        // Reset behaviour
        tick();
        tick();
        check("rst_cmd_ready", {63'h0, cmd_ready}, 64'h0);
        check("rst_cyc", {62'h0, wbm_cyc_o, wbm_stb_o}, 64'h0);
        check("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_rsp_dat", {32'h0, rsp_dat}, 64'h0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {63'h0, cmd_ready}, 64'h1);
        tick();

        // Single write, one wait state, with launch latency check
        slv_wait = 16'd1;
        push(1'b1, 32'h3000_0000, 32'hA5A5_1234, 4'hF, mk_exp(1'b1, 1'b0, 32'h0));
        check("lat_stb_low", {63'h0, wbm_stb_o}, 64'h0);
        tick();
        check("lat_stb_high", {62'h0, wbm_cyc_o, wbm_stb_o}, 64'h3);
        check("wr_bus", {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o[26:0]},
              {1'b1, 4'hF, 32'h3000_0000, 27'h5A5_1234});
        check("wr_dat", {32'h0, wbm_dat_o}, {32'h0, 32'hA5A5_1234});
        expect_rsp("wr_rsp");
        check("wr_stb_len", 64'(last_len), 64'd2);

        // Single read, three wait states
        slv_wait = 16'd3;
        slv_fixed_en = 1'b1;
        slv_fixed = 32'hCAFE_0042;
        push(1'b0, 32'h3000_0010, 32'h0, 4'hF, mk_exp(1'b0, 1'b0, 32'hCAFE_0042));
        expect_rsp("rd_rsp");
        check("rd_stb_len", 64'(last_len), 64'd4);
        check("rd_adr_stable", {63'h0, adr_glitch}, 64'h0);
        slv_fixed_en = 1'b0;

        // Queue fill with responses stalled, then drain in order
        slv_wait = 16'd0;
        for (int i = 0; i < 5; i++) begin
            a = 32'h3000_0100 + 32'(i * 4);
            if (i % 2 == 0)
                push(1'b0, a, 32'h0, 4'hF, mk_exp(1'b0, 1'b0, slv_data(a)));
            else
                push(1'b1, a, 32'(i) * 32'h1111_1111, 4'(1 << i), mk_exp(1'b1, 1'b0, 32'h0));
        end
        check("fill_not_ready", {63'h0, cmd_ready}, 64'h0);
        check("fill_busy", {63'h0, busy}, 64'h1);
        for (int i = 0; i < 5; i++) expect_rsp("fill_rsp");
        check("drain_idle", {63'h0, busy}, 64'h0);

        // Timeout, then a normal command right behind it
        slv_wait = 16'hFFFF;
        a = 32'h3000_0200;
        push(1'b0, a, 32'h0, 4'hF, mk_exp(1'b0, 1'b1, 32'h0));
        push(1'b0, a + 32'd4, 32'h0, 4'hF, mk_exp(1'b0, 1'b0, slv_data(a + 32'd4)));
        expect_rsp("to_rsp");
        slv_wait = 16'd0;
        check("to_stb_len", 64'(last_len), 64'd255);
        expect_rsp("after_to_rsp");

        // Ack on the final timeout cycle wins
        slv_wait = 16'd254;
        slv_fixed_en = 1'b1;
        slv_fixed = 32'h1357_9BDF;
        push(1'b0, 32'h3000_0300, 32'h0, 4'h3, mk_exp(1'b0, 1'b0, 32'h1357_9BDF));
        expect_rsp("late_ack_rsp");
        check("late_ack_len", 64'(last_len), 64'd255);
        slv_fixed_en = 1'b0;

        // Reset while a cycle is in flight with two commands queued
        slv_wait = 16'hFFFF;
        for (int i = 0; i < 3; i++)
            push(1'b0, 32'h3000_0400 + 32'(i * 4), 32'h0, 4'hF, mk_exp(1'b0, 1'b1, 32'h0));
        tick();
        tick();
        check("mid_stb", {63'h0, wbm_stb_o}, 64'h1);
        rst = 1'b1;
        tick();
        check("mid_rst_cyc", {62'h0, wbm_cyc_o, wbm_stb_o}, 64'h0);
        check("mid_rst_rsp", {63'h0, rsp_valid}, 64'h0);
        check("mid_rst_busy", {63'h0, busy}, 64'h0);
        rst = 1'b0;
        #1;
        check("mid_rst_ready", {63'h0, cmd_ready}, 64'h1);
        exp_q.delete();
        slv_wait = 16'd0;
        rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid || wbm_stb_o) seen++;
        end
        rsp_ready = 1'b0;
        check("no_rsp_after_rst", 64'(seen), 64'd0);
        a = 32'h3000_0500;
        push(1'b0, a, 32'h0, 4'hF, mk_exp(1'b0, 1'b0, slv_data(a)));
        expect_rsp("post_rst_rsp");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
